// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, cascaded 8-bit prescaler timebase and a
// four-state debounce FSM producing a clean level, press/release pulses and a press counter.
module button_debounce #(
    parameter int unsigned PRESCALE_STAGES = 2,
    parameter int unsigned STABLE_TICKS    = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   button_in,
    output logic                   level,
    output logic                   pressed,
    output logic                   released,
    output logic [COUNT_WIDTH-1:0] press_count,
    output logic                   tick
);

    localparam int unsigned CntWidth = $clog2(STABLE_TICKS + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(STABLE_TICKS - 1);
    localparam logic IdlePin = ACTIVE_LOW;

    typedef enum logic [1:0] {StIdle, StPressPend, StHeld, StReleasePend} state_t;

    logic                              sync_meta;
    logic                              sync_out;
    logic                              raw;
    logic [PRESCALE_STAGES-1:0][7:0]   stage_q;
    logic [PRESCALE_STAGES-1:0]        stage_en;
    state_t                            state;
    logic [CntWidth-1:0]               cnt;

    // Two-flop synchroniser, reset to the released pin value so reset release is quiet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= IdlePin;
            sync_out  <= IdlePin;
        end else begin
            sync_meta <= button_in;
            sync_out  <= sync_meta;
        end
    end

    // 1 = pressed, independent of pin polarity.
    assign raw = sync_out ^ ACTIVE_LOW;

    // Stage k advances only when every lower stage is saturated (shallow carry per stage).
    for (genvar k = 0; k < PRESCALE_STAGES; k++) begin : g_stage_en
        if (k == 0) begin : g_first
            assign stage_en[k] = 1'b1;
        end else begin : g_upper
            assign stage_en[k] = &stage_q[k-1:0];
        end
    end

    // Prescaler stages plus registered tick one cycle after all stages read 8'hFF.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
            tick    <= 1'b0;
        end else begin
            for (int k = 0; k < PRESCALE_STAGES; k++) begin
                if (stage_en[k]) begin
                    stage_q[k] <= stage_q[k] + 8'd1;
                end
            end
            tick <= &stage_q;
        end
    end

    // Debounce FSM; an abort (raw back to the stable value) wins over a commit on a tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            cnt         <= '0;
            level       <= 1'b0;
            pressed     <= 1'b0;
            released    <= 1'b0;
            press_count <= '0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            case (state)
                StIdle: begin
                    if (raw) begin
                        state <= StPressPend;
                        cnt   <= '0;
                    end
                end
                StPressPend: begin
                    if (!raw) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CntLast) begin
                            state       <= StHeld;
                            cnt         <= '0;
                            level       <= 1'b1;
                            pressed     <= 1'b1;
                            press_count <= press_count + COUNT_WIDTH'(1);
                        end else begin
                            cnt <= cnt + CntWidth'(1);
                        end
                    end
                end
                StHeld: begin
                    if (!raw) begin
                        state <= StReleasePend;
                        cnt   <= '0;
                    end
                end
                StReleasePend: begin
                    if (raw) begin
                        state <= StHeld;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CntLast) begin
                            state    <= StIdle;
                            cnt      <= '0;
                            level    <= 1'b0;
                            released <= 1'b1;
                        end else begin
                            cnt <= cnt + CntWidth'(1);
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised bench for button_debounce. Main instance uses P=256, 4 stable ticks, active-low pin
// and is compared every cycle against a tick-counting reference model. A second instance
// (active-high, 1 stable tick, 4-bit counter) exercises press_count wrap quickly.
module tb_button_debounce;

    localparam int P  = 256;
    localparam int ST = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       button_in;
    logic       level, pressed, released, tick;
    logic [7:0] press_count;

    logic       w_button;
    logic       w_level, w_pressed, w_released, w_tick;
    logic [3:0] w_count;

    int n_cmp = 0;
    int n_bad = 0;

    button_debounce #(
        .PRESCALE_STAGES(1), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1), .COUNT_WIDTH(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .button_in(button_in), .level(level),
        .pressed(pressed), .released(released), .press_count(press_count), .tick(tick)
    );

    button_debounce #(
        .PRESCALE_STAGES(1), .STABLE_TICKS(1), .ACTIVE_LOW(1'b0), .COUNT_WIDTH(4)
    ) dut_wrap (
        .clock(clock), .reset_n(reset_n), .button_in(w_button), .level(w_level),
        .pressed(w_pressed), .released(w_released), .press_count(w_count), .tick(w_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a change commits once STABLE_TICKS ticks have been seen while the
    // synchronised input continuously differs from the committed level.
    int         e      = 0;   // edges since reset release
    int         pend   = 0;   // edge the pending period began, 0 = none
    logic       p1     = 1'b1;
    logic       p2     = 1'b1;
    logic       raw_m  = 1'b0;
    logic       lvl_m  = 1'b0;
    logic       prs_m  = 1'b0;
    logic       rel_m  = 1'b0;
    logic       tck_m  = 1'b0;
    logic [7:0] cnt_m  = 8'd0;

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            e = 0; pend = 0; p1 = 1'b1; p2 = 1'b1;
            lvl_m = 1'b0; prs_m = 1'b0; rel_m = 1'b0; tck_m = 1'b0; cnt_m = 8'd0;
        end else begin
            e++;
            raw_m = ~p2;
            p2 = p1;
            p1 = button_in;
            prs_m = 1'b0;
            rel_m = 1'b0;
            if (raw_m != lvl_m) begin
                if (pend == 0) begin
                    pend = e;
                end else if ((e - 1) / P - (pend - 1) / P >= ST) begin
                    lvl_m = raw_m;
                    pend  = 0;
                    if (raw_m) begin
                        prs_m = 1'b1;
                        cnt_m = cnt_m + 8'd1;
                    end else begin
                        rel_m = 1'b1;
                    end
                end
            end else begin
                pend = 0;
            end
            tck_m = (e % P == 0);
        end
    end

    // Per-cycle comparison plus pulse/tick bookkeeping, sampled on the falling edge.
    int n_press = 0;
    int n_rel   = 0;
    int n_tick  = 0;
    int press_e = 0;

    initial forever begin
        @(negedge clock);
        check("cycle", {20'd0, level, pressed, released, tick, press_count},
              {20'd0, lvl_m, prs_m, rel_m, tck_m, cnt_m});
        if (pressed === 1'b1) begin
            n_press++;
            press_e = e;
        end
        if (released === 1'b1) n_rel++;
        if (tick === 1'b1) n_tick++;
    end

    task automatic clear_counts();
        n_press = 0;
        n_rel   = 0;
        n_tick  = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_wrap(input bit want_press, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (want_press ? w_pressed : w_released) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    int e_start;
    int lat;
    bit ok;

    initial begin
        reset_n   = 1'b0;
        button_in = 1'b1;
        w_button  = 1'b0;
        cycles(3);
        check("rst_out", {level, pressed, released, tick, press_count}, 12'd0);

        // Reset release and tick period
        reset_n = 1'b1;
        clear_counts();
        cycles(2000);
        check("t1_press", n_press, 0);
        check("t1_rel", n_rel, 0);
        check("t1_ticks", n_tick, 2000 / P);

        // Clean press
        clear_counts();
        button_in = 1'b0;
        e_start = e;
        cycles(2000);
        lat = press_e - e_start;
        check("t2_press", n_press, 1);
        check("t2_lat_ok", (lat >= 772 && lat <= 1027), 1);
        check("t2_level", level, 1);
        check("t2_count", press_count, 1);

        // Bounce then hold pressed
        button_in = 1'b1;
        cycles(2000);
        pulse_reset();
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            button_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(50);
        end
        check("t3_bounce", n_press, 0);
        button_in = 1'b0;
        cycles(2000);
        check("t3_press", n_press, 1);
        check("t3_count", press_count, 1);

        // Release with bounce
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            button_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            cycles(50);
        end
        check("t4_bounce", n_rel, 0);
        button_in = 1'b1;
        cycles(2000);
        check("t4_rel", n_rel, 1);
        check("t4_press", n_press, 0);
        check("t4_level", level, 0);
        check("t4_count", press_count, 1);

        // Random pin activity against the model
        for (int i = 0; i < 30; i++) begin
            button_in = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 1200));
        end
        button_in = 1'b1;
        cycles(1100);

        // Counter wrap on the fast instance
        for (int i = 1; i <= 16; i++) begin
            w_button = 1'b1;
            wait_wrap(1'b1, ok);
            check("wrap_press_seen", ok, 1);
            check("wrap_count", w_count, i % 16);
            check("wrap_level_hi", w_level, 1);
            w_button = 1'b0;
            wait_wrap(1'b0, ok);
            check("wrap_rel_seen", ok, 1);
            check("wrap_level_lo", w_level, 0);
        end

        // Reset while a press is pending
        pulse_reset();
        clear_counts();
        button_in = 1'b0;
        cycles(600);
        reset_n = 1'b0;
        #1;
        check("t6_async", {level, pressed, released, tick, press_count}, 12'd0);
        cycles(3);
        reset_n   = 1'b1;
        button_in = 1'b1;
        cycles(1500);
        check("t6_press", n_press, 0);
        check("t6_count", press_count, 0);
        check("t6_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
